// File: rtl/ser_word_feeder_if.sv
//------------------------------------------------------------------------------
// ser_word_feeder_if
//   Producer-side word handshake into ser_word_feeder.
//
//   Signals:
//     word_i  [WORD_W] : parallel word from the producer
//     valid_i          : word_i is valid this cycle
//     ready_o          : feeder can accept a word this cycle
//
//   A word transfers on every rising edge where valid_i and ready_o are both
//   high.
//
//   Modports:
//     master : producer side (drives word_i/valid_i, observes ready_o)
//     slave  : ser_word_feeder side
//------------------------------------------------------------------------------
interface ser_word_feeder_if #(
    parameter int unsigned WORD_W = 32
);
    logic [WORD_W-1:0] word_i;
    logic              valid_i;
    logic              ready_o;

    modport master (
        output word_i,
        output valid_i,
        input  ready_o
    );

    modport slave (
        input  word_i,
        input  valid_i,
        output ready_o
    );
endinterface

// File: rtl/ser_word_feeder.sv
//------------------------------------------------------------------------------
// ser_word_feeder
//   Buffers parallel words from a producer in a small FIFO and presents them
//   to a serializer leaf as LANE_W-bit beats, LSB-first, one beat per cycle.
//   Consecutive words stream with no bubble; when the stream runs dry after a
//   word, the lanes return to IDLE_PAT and underflow_o pulses for one cycle.
//
//   Parameters:
//     WORD_W     : parallel word width (multiple of LANE_W)
//     LANE_W     : bits per beat presented to the serializer leaf
//     FIFO_DEPTH : word buffer depth, power of two, >= 2
//     IDLE_PAT   : lane value driven when no payload is available
//
//   Ports:
//     clk_i        : system clock, all state updates on the rising edge
//     rst_i        : synchronous active-high reset
//     prod_if      : word_i / valid_i / ready_o producer handshake (slave)
//     lanes_o      : registered beat, bit 0 serialized first
//     lane_valid_o : registered, lanes_o carries payload
//     underflow_o  : one-cycle pulse in the first idle cycle after a word
//
//   Optional feature (macro SER_FEEDER_TRAIN_EN):
//     When defined, the block leaves reset into a training state that drives
//     16 alternating 1010/0101 beats (lane_valid_o low) before payload.
//     Words are accepted and buffered during training. When undefined the
//     training state and its counter are not built and reset exits to idle.
//------------------------------------------------------------------------------
module ser_word_feeder #(
    parameter int unsigned       WORD_W     = 32,
    parameter int unsigned       LANE_W     = 4,
    parameter int unsigned       FIFO_DEPTH = 4,
    parameter logic [LANE_W-1:0] IDLE_PAT   = '0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    ser_word_feeder_if.slave  prod_if,
    output logic [LANE_W-1:0] lanes_o,
    output logic              lane_valid_o,
    output logic              underflow_o
);

    //--------------------------------------------------------------------------
    // Derived sizes
    //--------------------------------------------------------------------------
    localparam int unsigned BEATS  = WORD_W / LANE_W;
    localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);

    //--------------------------------------------------------------------------
    // FSM state encodings
    //--------------------------------------------------------------------------
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
`ifdef SER_FEEDER_TRAIN_EN
    localparam logic [1:0] ST_TRAIN = 2'd2;
    localparam logic [1:0] ST_RESET_EXIT = ST_TRAIN;

    localparam logic [4:0] TRAIN_BEATS = 5'd16;
    // 1010... pattern truncated to the lane width; the other phase is its
    // complement.
    localparam logic [LANE_W-1:0] TRAIN_A = LANE_W'({(LANE_W + 1) / 2{2'b10}});
`else
    localparam logic [1:0] ST_RESET_EXIT = ST_IDLE;
`endif

    //--------------------------------------------------------------------------
    // State
    //--------------------------------------------------------------------------
    logic [1:0]        state_q,      state_d;
    logic [WORD_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q,     wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q,     rd_ptr_d;
    logic [CNT_W-1:0]  count_q,      count_d;
    logic [WORD_W-1:0] sreg_q,       sreg_d;
    logic [BEAT_W-1:0] beat_q,       beat_d;
    logic [LANE_W-1:0] lanes_q,      lanes_d;
    logic              lane_valid_q, lane_valid_d;
    logic              underflow_q,  underflow_d;
`ifdef SER_FEEDER_TRAIN_EN
    logic [4:0]        train_cnt_q,  train_cnt_d;
`endif

    logic              ready;
    logic              push;
    logic              load;
    logic              fifo_empty;
    logic [WORD_W-1:0] head_word;

    //--------------------------------------------------------------------------
    // FIFO status and producer handshake
    //--------------------------------------------------------------------------
    // count_q never exceeds FIFO_DEPTH, so "not full" is count < FIFO_DEPTH.
    // Ready depends only on the registered count: a pop in the same cycle
    // does not reopen a full FIFO.
    assign fifo_empty      = (count_q == '0);
    assign ready           = !rst_i && (count_q != FULL_CNT);
    assign prod_if.ready_o = ready;
    assign push            = prod_if.valid_i && ready;
    assign head_word       = mem_q[rd_ptr_q];

    //--------------------------------------------------------------------------
    // Sequencer next-state logic
    //--------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        sreg_d       = sreg_q;
        beat_d       = beat_q;
        lanes_d      = lanes_q;
        lane_valid_d = lane_valid_q;
        underflow_d  = 1'b0;
        load         = 1'b0;
`ifdef SER_FEEDER_TRAIN_EN
        train_cnt_d  = train_cnt_q;
`endif

        case (state_q)
`ifdef SER_FEEDER_TRAIN_EN
            ST_TRAIN: begin
                if (train_cnt_q != TRAIN_BEATS) begin
                    lanes_d      = train_cnt_q[0] ? ~TRAIN_A : TRAIN_A;
                    lane_valid_d = 1'b0;
                    train_cnt_d  = train_cnt_q + 5'd1;
                end else if (!fifo_empty) begin
                    load = 1'b1;
                end else begin
                    state_d      = ST_IDLE;
                    lanes_d      = IDLE_PAT;
                    lane_valid_d = 1'b0;
                end
            end
`endif
            ST_IDLE: begin
                lanes_d      = IDLE_PAT;
                lane_valid_d = 1'b0;
                if (!fifo_empty) begin
                    load = 1'b1;
                end
            end

            ST_SHIFT: begin
                if (beat_q != LAST_BEAT) begin
                    lanes_d      = sreg_q[LANE_W-1:0];
                    sreg_d       = sreg_q >> LANE_W;
                    beat_d       = beat_q + BEAT_W'(1);
                    lane_valid_d = 1'b1;
                end else if (!fifo_empty) begin
                    load = 1'b1;
                end else begin
                    state_d      = ST_IDLE;
                    lanes_d      = IDLE_PAT;
                    lane_valid_d = 1'b0;
                    underflow_d  = 1'b1;
                end
            end

            default: begin
                state_d      = ST_IDLE;
                lanes_d      = IDLE_PAT;
                lane_valid_d = 1'b0;
            end
        endcase

        // Loading a word registers its first beat directly, so the beat
        // appears the cycle after the pop and the last beat of one word is
        // followed immediately by the first beat of the next.
        if (load) begin
            state_d      = ST_SHIFT;
            lanes_d      = head_word[LANE_W-1:0];
            sreg_d       = head_word >> LANE_W;
            beat_d       = '0;
            lane_valid_d = 1'b1;
        end
    end

    //--------------------------------------------------------------------------
    // FIFO pointer / count next-state logic
    //--------------------------------------------------------------------------
    // Pointers are PTR_W bits wide, so they wrap modulo FIFO_DEPTH.
    always_comb begin
        wr_ptr_d = push ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
        rd_ptr_d = load ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
        case ({push, load})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    //--------------------------------------------------------------------------
    // Registers
    //--------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_RESET_EXIT;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            sreg_q       <= '0;
            beat_q       <= '0;
            lanes_q      <= IDLE_PAT;
            lane_valid_q <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            sreg_q       <= sreg_d;
            beat_q       <= beat_d;
            lanes_q      <= lanes_d;
            lane_valid_q <= lane_valid_d;
            underflow_q  <= underflow_d;
        end
    end

`ifdef SER_FEEDER_TRAIN_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            train_cnt_q <= '0;
        end else begin
            train_cnt_q <= train_cnt_d;
        end
    end
`endif

    // Storage needs no reset: clearing the pointers and count empties it.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= prod_if.word_i;
        end
    end

    //--------------------------------------------------------------------------
    // Outputs
    //--------------------------------------------------------------------------
    assign lanes_o      = lanes_q;
    assign lane_valid_o = lane_valid_q;
    assign underflow_o  = underflow_q;

endmodule

// File: doc/ser_word_feeder.md
SER_WORD_FEEDER -- requirements
Module: ser_word_feeder

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameter WORD_W, default 32, SHALL set the parallel word width in bits.
REQ-003 Parameter LANE_W, default 4, SHALL set the bits presented per cycle to the serializer leaf; WORD_W SHALL be a multiple of LANE_W.
REQ-004 Parameter FIFO_DEPTH, default 4, SHALL set the word buffer depth as a power of two, minimum 2.
REQ-005 Parameter IDLE_PAT, default 4'b0000, width LANE_W, SHALL set the lane value driven when no data is available.
REQ-006 clk_i  input  1  system clock; all state updates on its rising edge.
REQ-007 rst_i  input  1  synchronous active-high reset.
REQ-008 word_i  input  WORD_W  parallel word from the producer.
REQ-009 valid_i  input  1  word_i is valid.
REQ-010 ready_o  output  1  block can accept a word this cycle.
REQ-011 lanes_o  output  LANE_W  registered beat to the serializer leaf, bit 0 serialized first.
REQ-012 lane_valid_o  output  1  registered; lanes_o carries payload, not idle or training.
REQ-013 underflow_o  output  1  one-cycle pulse when the stream runs dry after a word.

Function
REQ-014 A word SHALL be accepted on every rising edge where valid_i and ready_o are both high, and written to the FIFO tail.
REQ-015 ready_o SHALL equal (FIFO count < FIFO_DEPTH), with no same-cycle bypass: a full FIFO SHALL deassert ready_o even when a pop occurs in the same cycle.
REQ-016 The FSM SHALL have states TRAIN, IDLE and SHIFT.
REQ-017 In IDLE, lanes_o SHALL equal IDLE_PAT and lane_valid_o SHALL be 0; on a non-empty FIFO, the FSM SHALL pop the head into the shift register and move to SHIFT.
REQ-018 Latency: a word accepted at the edge closing cycle N into an empty FIFO in IDLE SHALL present its first beat in cycle N+2.
REQ-019 In SHIFT, each cycle SHALL present the next LANE_W bits LSB-first, so one word takes WORD_W/LANE_W beats (8 at the defaults), with lane_valid_o high.
REQ-020 On the last beat with a non-empty FIFO, the next word SHALL load with no bubble cycle.
REQ-021 On the last beat with an empty FIFO, the FSM SHALL enter IDLE and underflow_o SHALL pulse high for exactly one cycle, the first IDLE cycle.
REQ-022 A simultaneous push and pop SHALL leave the FIFO count unchanged.
REQ-023 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-024 Each accepted word SHALL be emitted exactly once, in order, with no loss or duplication.

Reset
REQ-025 While rst_i is high, the block SHALL set lanes_o=IDLE_PAT, lane_valid_o=0, underflow_o=0 and ready_o=0, clear the FIFO, and discard any partially shifted word.
REQ-026 After rst_i falls, ready_o SHALL rise in the first cycle.
REQ-027 On leaving reset, the FSM SHALL enter TRAIN when training is compiled in and IDLE otherwise.
REQ-028 Reset asserted mid-word SHALL take effect at the next edge, and the remaining beats SHALL NOT be emitted.

Configuration
REQ-029 With macro SER_FEEDER_TRAIN_EN defined, the FSM SHALL spend 16 cycles in TRAIN after reset, driving alternating 4'b1010/4'b0101 starting with 1010 and lane_valid_o=0, then enter IDLE or SHIFT.
REQ-030 With SER_FEEDER_TRAIN_EN defined, words SHALL be accepted during TRAIN and held in the FIFO.
REQ-031 Without SER_FEEDER_TRAIN_EN, the TRAIN state and its counter SHALL be absent and reset SHALL exit directly to IDLE.

Verification
REQ-032 Single word 32'h8765_4321 accepted in IDLE -> lanes_o reads 1,2,3,4,5,6,7,8 in cycles N+2..N+9 with lane_valid_o high, then IDLE_PAT and one underflow_o pulse.
REQ-033 Back-to-back words 32'h1111_1111 then 32'h2222_2222 -> 16 contiguous valid beats (eight 1s then eight 2s), no gap, underflow_o only after beat 16.
REQ-034 Push 5 words with no gaps while valid_i is held high -> ready_o drops when count reaches 4, rises after a pop, and all 5 words emerge in order.
REQ-035 rst_i pulsed for 1 cycle at beat 3 of 32'hFFFF_FFFF with 2 words queued -> outputs at their reset values, no further payload beats, FIFO empty, ready_o=1 the next cycle.
REQ-036 SER_FEEDER_TRAIN_EN defined, word 32'hA5A5_A5A5 pushed in the 2nd cycle after reset -> 16 training beats 1010/0101, then payload 5,A,5,A,... with lane_valid_o high.
